// File: rtl/fft_spi_arbiter.sv
// fft_spi_arbiter: shares one FFT engine between two SPI sample channels, one whole frame at a time, round-robin on ties
module fft_spi_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] req0_msg,
    input  logic                 req0_val,
    output logic                 req0_rdy,
    input  logic [BIT_WIDTH-1:0] req1_msg,
    input  logic                 req1_val,
    output logic                 req1_rdy,
    output logic [BIT_WIDTH-1:0] fft_in_msg,
    output logic                 fft_in_val,
    input  logic                 fft_in_rdy,
    input  logic [BIT_WIDTH-1:0] fft_out_msg,
    input  logic                 fft_out_val,
    output logic                 fft_out_rdy,
    output logic [BIT_WIDTH-1:0] resp0_msg,
    output logic                 resp0_val,
    input  logic                 resp0_rdy,
    output logic [BIT_WIDTH-1:0] resp1_msg,
    output logic                 resp1_val,
    input  logic                 resp1_rdy,
    output logic                 grant,
    output logic                 busy
);
    localparam int CW = $clog2(N_SAMPLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t        state_q;
    logic          grant_q;
    logic          last_grant_q;
    logic [CW-1:0] in_cnt_q;
    logic [CW-1:0] out_cnt_q;
    logic          load;
    logic          drain;
    logic          in_fire;
    logic          out_fire;

    assign load     = state_q == LOAD;
    assign drain    = state_q == DRAIN;
    assign in_fire  = fft_in_val & fft_in_rdy;
    assign out_fire = fft_out_val & fft_out_rdy;
    assign grant    = grant_q;
    assign busy     = state_q != IDLE;

    // Zero-latency steering: granted request stream into the FFT in LOAD, FFT results back to it in DRAIN
    always_comb begin
        fft_in_msg  = load ? (grant_q ? req1_msg : req0_msg) : '0;
        fft_in_val  = load & (grant_q ? req1_val : req0_val);
        req0_rdy    = load & ~grant_q & fft_in_rdy;
        req1_rdy    = load & grant_q & fft_in_rdy;
        fft_out_rdy = drain & (grant_q ? resp1_rdy : resp0_rdy);
        resp0_msg   = (drain & ~grant_q) ? fft_out_msg : '0;
        resp1_msg   = (drain & grant_q) ? fft_out_msg : '0;
        resp0_val   = drain & ~grant_q & fft_out_val;
        resp1_val   = drain & grant_q & fft_out_val;
    end

    // Frame sequencing: arbitrate in IDLE, count N inputs in LOAD, count N results in DRAIN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (req0_val | req1_val) begin
                    grant_q <= (req0_val & req1_val) ? ~last_grant_q : req1_val;
                    state_q <= LOAD;
                end
                LOAD: if (in_fire) begin
                    in_cnt_q <= (in_cnt_q == LAST) ? '0 : in_cnt_q + 1'b1;
                    if (in_cnt_q == LAST) state_q <= DRAIN;
                end
                DRAIN: if (out_fire) begin
                    out_cnt_q <= (out_cnt_q == LAST) ? '0 : out_cnt_q + 1'b1;
                    if (out_cnt_q == LAST) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_spi_arbiter.sv
// tb_fft_spi_arbiter: directed scenarios with random stalls, checked against a transaction-level arbiter and echo-FFT model
module tb_fft_spi_arbiter;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req0_msg = '0, req1_msg = '0, fft_out_msg = '0;
    logic        req0_val = 1'b0, req1_val = 1'b0, fft_in_rdy = 1'b0;
    logic        fft_out_val = 1'b0, resp0_rdy = 1'b0, resp1_rdy = 1'b0;
    logic [31:0] fft_in_msg, resp0_msg, resp1_msg;
    logic        req0_rdy, req1_rdy, fft_in_val, fft_out_rdy;
    logic        resp0_val, resp1_val, grant, busy;

    int total = 0;
    int bad = 0;

    logic [31:0] src0[$], src1[$], fftq[$], exp0[$], exp1[$];
    int          order[$];
    int          ph = 0;
    bit          own = 1'b0;
    bit          last = 1'b1;
    int          m_in = 0;
    int          m_out = 0;
    int          n_in[2];
    int          n_out[2];
    bit          stall = 1'b0;

    always #5 clk = ~clk;

    fft_spi_arbiter #(.BIT_WIDTH(32), .N_SAMPLES(N)) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .fft_in_msg(fft_in_msg), .fft_in_val(fft_in_val), .fft_in_rdy(fft_in_rdy),
        .fft_out_msg(fft_out_msg), .fft_out_val(fft_out_val), .fft_out_rdy(fft_out_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit coin();
        return !stall || ($urandom_range(1, 0) == 1);
    endfunction

    task automatic drive();
        req0_val    = (src0.size() > 0) && coin();
        req0_msg    = (src0.size() > 0) ? src0[0] : 32'h0;
        req1_val    = (src1.size() > 0) && coin();
        req1_msg    = (src1.size() > 0) ? src1[0] : 32'h0;
        fft_in_rdy  = coin();
        fft_out_val = (fftq.size() > 0) && coin();
        fft_out_msg = (fftq.size() > 0) ? fftq[0] : 32'h0;
        resp0_rdy   = coin();
        resp1_rdy   = coin();
    endtask

    task automatic check_and_update();
        bit          ld = (ph == 1);
        bit          dr = (ph == 2);
        bit          own_val = own ? req1_val : req0_val;
        bit          own_rdy = own ? resp1_rdy : resp0_rdy;
        bit          fin = ld && own_val && fft_in_rdy;
        bit          fout = dr && fft_out_val && own_rdy;
        logic [31:0] v;
        chk("busy", busy, ph != 0);
        chk("grant", grant, own);
        chk("fft_in_val", fft_in_val, ld && own_val);
        chk("fft_in_msg", fft_in_msg, ld ? (own ? req1_msg : req0_msg) : 32'h0);
        chk("req0_rdy", req0_rdy, ld && !own && fft_in_rdy);
        chk("req1_rdy", req1_rdy, ld && own && fft_in_rdy);
        chk("fft_out_rdy", fft_out_rdy, dr && own_rdy);
        chk("resp0_val", resp0_val, dr && !own && fft_out_val);
        chk("resp1_val", resp1_val, dr && own && fft_out_val);
        chk("resp_other_msg", own ? resp0_msg : resp1_msg, 32'h0);
        if (dr) chk("resp_msg", own ? resp1_msg : resp0_msg, fft_out_msg);
        if (ph == 0) begin
            if (req0_val || req1_val) begin
                own = (req0_val && req1_val) ? !last : req1_val;
                order.push_back(int'(own));
                ph = 1;
            end
        end else if (fin) begin
            v = own ? src1.pop_front() : src0.pop_front();
            fftq.push_back(v + 32'd100);
            if (own) exp1.push_back(v + 32'd100);
            else exp0.push_back(v + 32'd100);
            n_in[own]++;
            m_in++;
            if (m_in == N) begin
                m_in = 0;
                ph = 2;
            end
        end else if (fout) begin
            v = own ? exp1.pop_front() : exp0.pop_front();
            chk("resp_order", own ? resp1_msg : resp0_msg, v);
            void'(fftq.pop_front());
            n_out[own]++;
            m_out++;
            if (m_out == N) begin
                m_out = 0;
                last = own;
                ph = 0;
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int maxc);
        int  c = 0;
        bit  done;
        do begin
            cycle();
            c++;
            done = (ph == 0) && (src0.size() == 0) && (src1.size() == 0) && (fftq.size() == 0);
        end while (!done && c < maxc);
        chk("run_done", done, 1'b1);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_fft_in_val", fft_in_val, 1'b0);
        chk("rst_req0_rdy", req0_rdy, 1'b0);
        chk("rst_req1_rdy", req1_rdy, 1'b0);
        chk("rst_fft_out_rdy", fft_out_rdy, 1'b0);
        chk("rst_resp0_val", resp0_val, 1'b0);
        chk("rst_resp1_val", resp1_val, 1'b0);
        src0.delete(); src1.delete(); fftq.delete(); exp0.delete(); exp1.delete(); order.delete();
        ph = 0; own = 1'b0; last = 1'b1; m_in = 0; m_out = 0;
        n_in[0] = 0; n_in[1] = 0; n_out[0] = 0; n_out[1] = 0;
        req0_val = 1'b0; req1_val = 1'b0; fft_out_val = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        stall = 1'b0;
        for (int k = 1; k <= N; k++) src1.push_back(32'(k));
        run(200);
        chk("a_in1", n_in[1], N);
        chk("a_out1", n_out[1], N);
        chk("a_in0", n_in[0], 0);
        chk("a_owner", order.size() > 0 ? order[0] : -1, 1);

        do_reset();
        for (int k = 0; k < 2 * N; k++) src0.push_back(32'h1000 + 32'(k));
        for (int k = 0; k < N; k++) src1.push_back(32'h2000 + 32'(k));
        run(400);
        chk("b_frames", order.size(), 3);
        chk("b_ord0", order.size() > 0 ? order[0] : -1, 0);
        chk("b_ord1", order.size() > 1 ? order[1] : -1, 1);
        chk("b_ord2", order.size() > 2 ? order[2] : -1, 0);
        chk("b_out0", n_out[0], 2 * N);
        chk("b_out1", n_out[1], N);

        do_reset();
        stall = 1'b1;
        for (int k = 0; k < N; k++) src0.push_back($urandom);
        run(2000);
        chk("c_in0", n_in[0], N);
        chk("c_out0", n_out[0], N);
        chk("c_out1", n_out[1], 0);
        stall = 1'b0;

        do_reset();
        for (int k = 0; k < N; k++) src0.push_back(32'h4000 + 32'(k));
        for (int c = 0; c < 50 && m_in < 5; c++) cycle();
        chk("d_reach5", m_in, 5);
        chk("d_busy_mid", busy, 1'b1);
        do_reset();
        for (int k = 0; k < N; k++) src0.push_back(32'h5000 + 32'(k));
        run(200);
        chk("d_in0", n_in[0], N);
        chk("d_out0", n_out[0], N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_spi_arbiter.md
Name: fft_spi_arbiter

Overview:
Shares one FFT engine between the two SPI minion channels. Each channel delivers sample frames as a val/rdy stream. The arbiter grants the engine to one channel for a whole frame of N_SAMPLES input samples, then routes the N_SAMPLES FFT outputs back to that same channel. Frames never interleave, and grants alternate round-robin when both channels are waiting. It sits between the SPI minion adapters and the FFT datapath inside the user project.

Parameters:
BIT_WIDTH, 32, width of every sample/message bus
N_SAMPLES, 8, samples per frame in and out; power of two, 2..256

Ports:
clk  input  1  system clock (wb_clk_i at the wrapper)
reset  input  1  asynchronous, active-high reset
req0_msg  input  BIT_WIDTH  channel 0 input sample
req0_val  input  1  channel 0 sample valid
req0_rdy  output  1  channel 0 sample accepted
req1_msg  input  BIT_WIDTH  channel 1 input sample
req1_val  input  1  channel 1 sample valid
req1_rdy  output  1  channel 1 sample accepted
fft_in_msg  output  BIT_WIDTH  sample to FFT
fft_in_val  output  1  FFT input valid
fft_in_rdy  input  1  FFT input ready
fft_out_msg  input  BIT_WIDTH  FFT result
fft_out_val  input  1  FFT result valid
fft_out_rdy  output  1  FFT result accepted
resp0_msg  output  BIT_WIDTH  result to channel 0
resp0_val  output  1  result valid, channel 0
resp0_rdy  input  1  channel 0 ready for result
resp1_msg  output  BIT_WIDTH  result to channel 1
resp1_val  output  1  result valid, channel 1
resp1_rdy  input  1  channel 1 ready for result
grant  output  1  channel currently owning the FFT
busy  output  1  high in LOAD or DRAIN

Behaviour:
- Transfer ("fire") occurs on a cycle where val and rdy are both high at a rising clk edge.
- State register values: IDLE, LOAD, DRAIN. Registers: grant, last_grant, in_cnt, out_cnt, each clog2(N_SAMPLES)+1 bits.
- Reset (async, immediate): state=IDLE, grant=0, last_grant=1 (channel 0 wins the first tie), in_cnt=0, out_cnt=0.
- Reset output values: all val/rdy outputs 0, busy=0, grant=0.
- IDLE behaviour:
  - All rdy/val outputs are 0.
  - If exactly one reqX_val is high, grant<=X.
  - If both are high, grant<=~last_grant.
  - If either is high, go to LOAD next cycle. This costs one arbitration cycle; no sample moves in IDLE.
- LOAD behaviour:
  - fft_in_msg=req[grant]_msg, fft_in_val=req[grant]_val, req[grant]_rdy=fft_in_rdy. These paths are combinational with zero latency.
  - Non-granted req_rdy=0.
  - in_cnt increments on each fft_in fire. On the N_SAMPLES-th fire, in_cnt<=0 and state<=DRAIN.
  - fft_out_rdy=0. Results produced early are held by the FFT under backpressure.
- DRAIN behaviour:
  - resp[grant]_msg=fft_out_msg, resp[grant]_val=fft_out_val, fft_out_rdy=resp[grant]_rdy. These paths are combinational.
  - Other resp_val=0. All req_rdy=0, fft_in_val=0.
  - out_cnt increments on each fft_out fire. On the N_SAMPLES-th fire, out_cnt<=0, last_grant<=grant, state<=IDLE.
- resp_msg of the non-granted channel is driven 0. fft_in_msg is 0 outside LOAD.
- grant holds steady from the IDLE decision until the next IDLE decision. A requester dropping val mid-frame only stalls the frame; the grant is never revoked.
- Counters never wrap past N_SAMPLES. Back-to-back frames from the same channel are allowed if the other channel is idle.
- Reset asserted mid-frame aborts it: counters clear and the partial frame is discarded. Resynchronising the FFT is the FFT's own reset responsibility (same reset net).
- Minimum frame latency (no stalls): 1 + N_SAMPLES cycles of LOAD, then DRAIN paced by the FFT.

Test Plan:
- Reset asserted asynchronously between clock edges -> busy, all val/rdy drop to 0 immediately, grant=0.
- Only req1 streams 8 samples 1..8 (N=8); FFT model echoes +100 -> grant=1, fft_in sees 1..8 in order, resp1 receives 101..108, resp0_val never high, state back to IDLE.
- req0 and req1 both valid from the first cycle after reset -> channel 0 served first, then channel 1, then channel 0 again; no cross-channel samples on fft_in.
- Random stalls on req0_val, fft_in_rdy, resp0_rdy (about 50%) -> exactly 8 inputs and 8 outputs, order preserved, no duplicates or drops.
- FFT asserts fft_out_val during LOAD -> fft_out_rdy stays 0 until DRAIN; no result lost.
- Reset pulse after 5 of 8 samples loaded -> IDLE; the next frame of 8 completes normally with in_cnt restarting at 0.
